// File: rtl/fifo_ftdi_tx_ctrl.sv
// Burst adapter that drains a standard-mode FIFO into an FT245-style FTDI transmit port.
// Fetches one byte at a time, holds it through FTXE stalls, and strobes FWR with programmable timing.
module fifo_ftdi_tx_ctrl #(
  parameter int DATA_W       = 8,
  parameter int USEDW_W      = 11,
  parameter int MIN_LEVEL    = 1,
  parameter int BURST_LEN    = 64,
  parameter int FWR_LOW_CYC  = 1,
  parameter int FWR_HIGH_CYC = 1,
  parameter int GATE_ON_WR   = 1
) (
  input  logic               rdclk,
  input  logic               rst_n,
  input  logic [USEDW_W-1:0] usedw,
  input  logic               wrreq,
  input  logic [DATA_W-1:0]  fifo_q,
  output logic               rdreq,
  input  logic               ftdi_en,
  input  logic               FTXE,
  output logic               FWR,
  output logic [DATA_W-1:0]  fd_out,
  output logic               fd_oe,
  output logic               tx_busy,
  output logic [31:0]        tx_count
);

  localparam int PH_MAX = (FWR_LOW_CYC > FWR_HIGH_CYC) ? FWR_LOW_CYC : FWR_HIGH_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int BC_W   = $clog2(BURST_LEN + 1);

  localparam logic [PH_W-1:0]    LOW_LAST  = PH_W'(FWR_LOW_CYC - 1);
  localparam logic [PH_W-1:0]    HIGH_LAST = PH_W'(FWR_HIGH_CYC - 1);
  localparam logic [BC_W-1:0]    BURST_MAX = BC_W'(BURST_LEN);
  localparam logic [USEDW_W-1:0] MIN_USEDW = USEDW_W'(MIN_LEVEL);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, STROBE, RECOVER} state_t;

  state_t          state;
  state_t          next_state;
  logic [PH_W-1:0] phase;
  logic [BC_W-1:0] burst_cnt;
  logic            first_load;
  logic            start_ok;
  logic            cont_ok;
  logic            strobe_done;
  logic            recover_done;

  assign start_ok     = ftdi_en && !FTXE && (usedw >= MIN_USEDW) && ((GATE_ON_WR == 0) || !wrreq);
  // wrreq is deliberately ignored once a burst is running.
  assign cont_ok      = (burst_cnt < BURST_MAX) && ftdi_en && !FTXE && (usedw != '0);
  assign strobe_done  = (state == STROBE) && (phase == LOW_LAST);
  assign recover_done = (state == RECOVER) && (phase == HIGH_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rdreq      <= 1'b0;
      FWR        <= 1'b1;
      fd_oe      <= 1'b0;
      fd_out     <= '0;
      tx_count   <= '0;
      burst_cnt  <= '0;
      phase      <= '0;
      first_load <= 1'b0;
    end else begin
      state      <= next_state;
      rdreq      <= (next_state == FETCH);
      // FWR comes straight from a flop so the pin never glitches on state decode.
      FWR        <= (next_state != STROBE);
      first_load <= (state == FETCH);

      if (state != next_state)
        phase <= '0;
      else if (state == STROBE || state == RECOVER)
        phase <= phase + 1'b1;

      // fifo_q is valid only in the first LOAD cycle; capture it once and hold through stalls.
      if (first_load)
        fd_out <= fifo_q;

      if (state == FETCH)
        fd_oe <= 1'b1;
      else if (next_state == IDLE)
        fd_oe <= 1'b0;

      if (state == IDLE && next_state == FETCH)
        burst_cnt <= '0;
      else if (strobe_done)
        burst_cnt <= burst_cnt + 1'b1;

      if (strobe_done)
        tx_count <= tx_count + 32'd1;
    end
  end

  // NOTE: next_state gets a default first so no path through the case infers a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_ok) next_state = FETCH;
      FETCH:   next_state = LOAD;
      LOAD:    if (!FTXE) next_state = STROBE;
      STROBE:  if (strobe_done) next_state = RECOVER;
      RECOVER: if (recover_done) next_state = cont_ok ? FETCH : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    tx_busy = (state != IDLE);
  end

endmodule

// File: tb/tb_fifo_ftdi_tx_ctrl.sv
// Self-checking bench: two instances (short-burst and slow-strobe/threshold configs) fed by FIFO models.
// Bytes written to each FIFO are queued as expected strobe data and popped when FWR falls.
module tb_fifo_ftdi_tx_ctrl;
  localparam int DW = 8;
  localparam int UW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [UW-1:0] usedw_a, usedw_b;
  logic          wrreq_a, wrreq_b, en_a, en_b, ftxe_a, ftxe_b;
  logic          rdreq_a, rdreq_b, fwr_a, fwr_b, fd_oe_a, fd_oe_b, busy_a, busy_b;
  logic [DW-1:0] fifo_q_a = '0, fifo_q_b = '0;
  logic [DW-1:0] fd_out_a, fd_out_b;
  logic [31:0]   tx_count_a, tx_count_b;

  fifo_ftdi_tx_ctrl #(.DATA_W(DW), .USEDW_W(UW), .MIN_LEVEL(1), .BURST_LEN(4),
                      .FWR_LOW_CYC(1), .FWR_HIGH_CYC(1), .GATE_ON_WR(1)) dut_a (
    .rdclk(clk), .rst_n(rst_n), .usedw(usedw_a), .wrreq(wrreq_a), .fifo_q(fifo_q_a),
    .rdreq(rdreq_a), .ftdi_en(en_a), .FTXE(ftxe_a), .FWR(fwr_a), .fd_out(fd_out_a),
    .fd_oe(fd_oe_a), .tx_busy(busy_a), .tx_count(tx_count_a));

  fifo_ftdi_tx_ctrl #(.DATA_W(DW), .USEDW_W(UW), .MIN_LEVEL(16), .BURST_LEN(64),
                      .FWR_LOW_CYC(3), .FWR_HIGH_CYC(1), .GATE_ON_WR(1)) dut_b (
    .rdclk(clk), .rst_n(rst_n), .usedw(usedw_b), .wrreq(wrreq_b), .fifo_q(fifo_q_b),
    .rdreq(rdreq_b), .ftdi_en(en_b), .FTXE(ftxe_b), .FWR(fwr_b), .fd_out(fd_out_b),
    .fd_oe(fd_oe_b), .tx_busy(busy_b), .tx_count(tx_count_b));

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // FIFO models: reads pop at the rdreq edge so data appears the following cycle.
  logic [DW-1:0] fq_a[$], fq_b[$], expq_a[$], expq_b[$];
  int unsigned n_wr_a = 0, n_rd_a = 0, n_wr_b = 0, n_rd_b = 0;
  assign usedw_a = UW'(n_wr_a - n_rd_a);
  assign usedw_b = UW'(n_wr_b - n_rd_b);

  always @(posedge clk) begin
    if (rdreq_a && fq_a.size() != 0) begin
      fifo_q_a <= fq_a.pop_front();
      n_rd_a   <= n_rd_a + 1;
    end
    if (rdreq_b && fq_b.size() != 0) begin
      fifo_q_b <= fq_b.pop_front();
      n_rd_b   <= n_rd_b + 1;
    end
  end

  task automatic push_a(input logic [DW-1:0] v);
    fq_a.push_back(v); expq_a.push_back(v); n_wr_a++;
  endtask
  task automatic push_b(input logic [DW-1:0] v);
    fq_b.push_back(v); expq_b.push_back(v); n_wr_b++;
  endtask

  // Output monitors sampled on the falling edge.
  logic   prev_fwr_a = 1'b1, prev_rd_a = 1'b0, prev_fwr_b = 1'b1, prev_rd_b = 1'b0;
  int     low_a = 0, low_b = 0, strobes_a = 0, strobes_b = 0, rdp_a = 0, rdp_b = 0;
  longint fall_a[$];
  logic [DW-1:0] sb_b = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_fwr_a = 1'b1; prev_rd_a = 1'b0; low_a = 0;
    end else begin
      if (!fwr_a) begin
        if (prev_fwr_a) begin
          strobes_a++;
          fall_a.push_back($time);
          check("a_strobe_expected", 32'(expq_a.size() != 0), 1);
          if (expq_a.size() != 0) check("a_strobe_data", 32'(fd_out_a), 32'(expq_a.pop_front()));
          check("a_strobe_oe", 32'(fd_oe_a), 1);
        end
        low_a++;
      end else if (!prev_fwr_a) begin
        check("a_fwr_low_len", low_a, 1);
        low_a = 0;
      end
      if (rdreq_a) begin
        rdp_a++;
        check("a_rdreq_nonempty", 32'(usedw_a != 0), 1);
        check("a_rdreq_single", 32'(prev_rd_a), 0);
      end
      prev_fwr_a = fwr_a; prev_rd_a = rdreq_a;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_fwr_b = 1'b1; prev_rd_b = 1'b0; low_b = 0;
    end else begin
      if (!fwr_b) begin
        if (prev_fwr_b) begin
          strobes_b++;
          sb_b = fd_out_b;
          check("b_strobe_expected", 32'(expq_b.size() != 0), 1);
          if (expq_b.size() != 0) check("b_strobe_data", 32'(fd_out_b), 32'(expq_b.pop_front()));
          check("b_strobe_oe", 32'(fd_oe_b), 1);
        end else begin
          check("b_strobe_stable", 32'(fd_out_b), 32'(sb_b));
        end
        low_b++;
      end else if (!prev_fwr_b) begin
        check("b_fwr_low_len", low_b, 3);
        low_b = 0;
      end
      if (rdreq_b) begin
        rdp_b++;
        check("b_rdreq_nonempty", 32'(usedw_b != 0), 1);
        check("b_rdreq_single", 32'(prev_rd_b), 0);
      end
      prev_fwr_b = fwr_b; prev_rd_b = rdreq_b;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rd0, st0;
    rst_n = 1'b0;
    en_a = 1'b1; ftxe_a = 1'b0; wrreq_a = 1'b0;
    en_b = 1'b1; ftxe_b = 1'b0; wrreq_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_fwr_a", 32'(fwr_a), 1);
    check("rst_rdreq_a", 32'(rdreq_a), 0);
    check("rst_oe_a", 32'(fd_oe_a), 0);
    check("rst_count_a", tx_count_a, 0);
    check("rst_fwr_b", 32'(fwr_b), 1);
    rst_n = 1'b1;

    // Idle with empty FIFOs.
    repeat (100) @(negedge clk);
    check("idle_rdreq_cnt_a", rdp_a, 0);
    check("idle_rdreq_cnt_b", rdp_b, 0);
    check("idle_fwr_a", 32'(fwr_a), 1);
    check("idle_oe_a", 32'(fd_oe_a), 0);
    check("idle_busy_a", 32'(busy_a), 0);
    check("idle_count_a", tx_count_a, 0);

    // Single byte.
    push_a(8'hA5);
    @(negedge clk);
    for (int n = 0; n < 50 && busy_a; n++) @(negedge clk);
    check("single_idle", 32'(busy_a), 0);
    check("single_rdreq_cnt", rdp_a, 1);
    check("single_strobes", strobes_a, 1);
    check("single_count", tx_count_a, 1);
    check("single_oe_off", 32'(fd_oe_a), 0);

    // Burst cap of 4 with 10 bytes queued: 4 + 4 + 2.
    fall_a.delete();
    for (int i = 0; i < 10; i++) push_a(8'(8'h10 + i));
    for (int n = 0; n < 200 && tx_count_a != 32'd11; n++) @(negedge clk);
    for (int n = 0; n < 20 && busy_a; n++) @(negedge clk);
    check("burst_count", tx_count_a, 11);
    check("burst_rdreq_cnt", rdp_a, 11);
    check("burst_idle", 32'(busy_a), 0);
    check("burst_strobes", 32'(fall_a.size()), 10);
    for (int i = 1; i < 10 && i < fall_a.size(); i++)
      check("burst_spacing", 32'(fall_a[i] - fall_a[i-1]), (i == 4 || i == 8) ? 32'd50 : 32'd40);

    // FTXE stall after the fetch: byte held, no extra read.
    rd0 = rdp_a; st0 = strobes_a;
    push_a(8'h3C);
    @(negedge clk);
    for (int n = 0; n < 20 && !rdreq_a; n++) @(negedge clk);
    check("stall_rdreq_seen", 32'(rdreq_a), 1);
    ftxe_a = 1'b1;
    repeat (10) @(negedge clk);
    check("stall_busy", 32'(busy_a), 1);
    check("stall_fwr", 32'(fwr_a), 1);
    check("stall_oe", 32'(fd_oe_a), 1);
    check("stall_data", 32'(fd_out_a), 32'h3C);
    check("stall_no_strobe", strobes_a, st0);
    ftxe_a = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 20 && busy_a; n++) @(negedge clk);
    check("stall_idle", 32'(busy_a), 0);
    check("stall_strobes", strobes_a, st0 + 1);
    check("stall_rdreq_cnt", rdp_a, rd0 + 1);
    check("stall_count", tx_count_a, 12);

    // Threshold and write gating on the MIN_LEVEL=16 instance.
    for (int i = 0; i < 15; i++) push_b(8'(8'h40 + i));
    repeat (20) @(negedge clk);
    check("thresh_no_start", rdp_b, 0);
    check("thresh_busy", 32'(busy_b), 0);
    wrreq_b = 1'b1;
    push_b(8'h4F);
    repeat (20) @(negedge clk);
    check("gate_no_start", rdp_b, 0);
    check("gate_busy", 32'(busy_b), 0);
    wrreq_b = 1'b0;
    @(negedge clk);
    check("gate_release_start", 32'(busy_b), 1);

    // Async reset on the second low cycle of a 3-cycle strobe.
    for (int n = 0; n < 100 && tx_count_b != 32'd2; n++) @(negedge clk);
    check("b_count_two", tx_count_b, 2);
    for (int n = 0; n < 20 && fwr_b; n++) @(negedge clk);
    @(negedge clk);
    check("b_second_low", 32'(fwr_b), 0);
    rst_n = 1'b0;
    #1;
    check("arst_fwr", 32'(fwr_b), 1);
    check("arst_oe", 32'(fd_oe_b), 0);
    check("arst_count", tx_count_b, 0);
    check("arst_data", 32'(fd_out_b), 0);
    check("arst_busy", 32'(busy_b), 0);
    check("arst_rdreq", 32'(rdreq_b), 0);
    check("arst_count_a", tx_count_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
